// File: rtl/i2s_rx_axis.sv
// I2S receiver: resynchronises SCLK/LRCLK/SDATA, deserialises each channel word and delivers
// sign-extended samples on an AXI4-Stream master through a small drop-on-overflow FIFO.
module i2s_rx_axis #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned FRAME_LEN    = 256,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        i_enable,
  input  logic        i_clear_overflow,
  input  logic        i2s_sclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_sdata,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        o_overflow,
  output logic [15:0] o_drop_count
);

  localparam int unsigned CntW = $clog2(SAMPLE_WIDTH);
  localparam int unsigned FcW  = $clog2(FRAME_LEN);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW = SAMPLE_WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StSync, StShift, StHold} state_e;

  logic                    r_rst_meta, r_rst_n;
  logic [2:0]              r_sclk_sync;
  logic [1:0]              r_lr_sync, r_sd_sync;
  logic                    r_lr_last;
  state_e                  r_state, w_state_next;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [CntW-1:0]         r_cnt;
  logic                    r_chan;
  logic [FcW-1:0]          r_frame_cnt;
  logic [EntW-1:0]         r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]           r_count;

  logic                    w_edge, w_lr, w_sd, w_lr_trans, w_sync_hit;
  logic [SAMPLE_WIDTH-1:0] w_shift_in, w_sample;
  logic [CntW-1:0]         w_pad;
  logic                    w_push, w_tlast_in, w_pop, w_full, w_accept, w_drop;
  logic [EntW-1:0]         w_head;

  // Asynchronous assert, synchronous release for everything downstream.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_sclk_sync <= '0;
      r_lr_sync   <= '0;
      r_sd_sync   <= '0;
      r_lr_last   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i2s_sclk};
      r_lr_sync   <= {r_lr_sync[0], i2s_lrclk};
      r_sd_sync   <= {r_sd_sync[0], i2s_sdata};
      if (w_edge) r_lr_last <= w_lr;
    end
  end

  assign w_edge     = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_lr       = r_lr_sync[1];
  assign w_sd       = r_sd_sync[1];
  assign w_lr_trans = w_edge & (w_lr ^ r_lr_last);
  assign w_sync_hit = w_edge & r_lr_last & ~w_lr;

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!i_enable) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  w_state_next = StSync;
        StSync:  if (w_sync_hit) w_state_next = StShift;
        StShift: if (w_edge && !w_lr_trans && r_cnt == CntW'(SAMPLE_WIDTH - 1))
                   w_state_next = StHold;
        StHold:  if (w_lr_trans) w_state_next = StShift;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // A word cut short by an LRCLK change is left-aligned by the bits it never received.
  always_comb begin
    w_shift_in = {r_shift[SAMPLE_WIDTH-2:0], w_sd};
    w_pad      = CntW'(SAMPLE_WIDTH - 1) - r_cnt;
    w_sample   = w_shift_in << w_pad;
    w_push     = 1'b0;
    if (i_enable && r_state == StShift && w_edge &&
        (w_lr_trans || r_cnt == CntW'(SAMPLE_WIDTH - 1))) begin
      w_push = 1'b1;
    end
    w_tlast_in = r_chan && (r_frame_cnt == FcW'(FRAME_LEN - 1));
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_chan      <= 1'b0;
      r_frame_cnt <= '0;
    end else if (!i_enable || r_state == StIdle) begin
      r_cnt       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        StSync: if (w_sync_hit) begin
          r_chan <= 1'b0;
          r_cnt  <= '0;
        end
        StShift: if (w_edge) begin
          r_shift <= w_shift_in;
          if (w_lr_trans) begin
            r_chan <= w_lr;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StHold: if (w_lr_trans) begin
          r_chan <= w_lr;
          r_cnt  <= '0;
        end
        default: ;
      endcase
      // Right-channel attempts advance the frame even when the sample is dropped.
      if (w_push && r_chan) begin
        r_frame_cnt <= (r_frame_cnt == FcW'(FRAME_LEN - 1)) ? '0 : r_frame_cnt + FcW'(1);
      end
    end
  end

  assign w_pop    = m_axis_tvalid & m_axis_tready;
  assign w_full   = (r_count == (PtrW + 1)'(FIFO_DEPTH));
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= {w_tlast_in, r_chan, w_sample};
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: ;
      endcase
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = 32'($signed(w_head[SAMPLE_WIDTH-1:0]));
  assign m_axis_tuser  = w_head[SAMPLE_WIDTH];
  assign m_axis_tlast  = w_head[SAMPLE_WIDTH+1];

  // A drop in the clearing cycle restarts the count at one.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (w_drop) begin
      o_overflow <= 1'b1;
      if (i_clear_overflow)          o_drop_count <= 16'd1;
      else if (o_drop_count != '1)   o_drop_count <= o_drop_count + 16'd1;
    end else if (i_clear_overflow) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_axis.sv
// Drives standard-format I2S words and checks the AXI stream against a word-level model of
// capture, framing and overflow.
module tb_i2s_rx_axis;

  localparam int SW = 24;
  localparam int FL = 4;
  localparam int FD = 4;

  logic        clk = 1'b0, aresetn = 1'b0, i_enable = 1'b0, i_clear_overflow = 1'b0;
  logic        sclk = 1'b0, lrclk = 1'b0, sdata = 1'b0, tready = 1'b1;
  logic [31:0] tdata;
  logic        tuser, tlast, tvalid, ovf;
  logic [15:0] drops;

  i2s_rx_axis #(.SAMPLE_WIDTH(SW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .aresetn(aresetn), .i_enable(i_enable), .i_clear_overflow(i_clear_overflow),
    .i2s_sclk(sclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .o_overflow(ovf), .o_drop_count(drops)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  logic [33:0] exp_q[$];
  logic [33:0] beat_log[$];
  int fc = 0, m_drops = 0;
  bit synced = 0, m_lr_last = 0, m_ovf = 0, stall = 0, carry = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_en(input bit v);
    i_enable = v;
    if (!v) begin synced = 0; fc = 0; end
  endtask

  task automatic slot(input bit lr, input bit d, input bit en_rise);
    sclk = 1'b0; lrclk = lr; sdata = d;
    cyc(3);
    if (en_rise) i_enable = 1'b1;
    cyc(3);
    sclk = 1'b1;
    cyc(6);
    m_lr_last = lr;
  endtask

  // One WS period of length p; the MSB follows the WS change by one slot.
  task automatic word(input bit ch, input logic [31:0] val, input int p, input int en_slot,
                      input int abort_slot);
    logic [23:0] e;
    bit          last;
    int          n;
    if (i_enable && (synced || (m_lr_last && !ch))) begin
      synced = 1;
      n = (p < SW) ? p : SW;
      e = val[31:8];
      for (int i = 0; i < SW - n; i++) e[i] = 1'b0;
      last = 0;
      if (ch) begin
        last = (fc == FL - 1);
        fc = (fc + 1) % FL;
      end
      if (stall && exp_q.size() >= FD) begin
        if (m_drops < 65535) m_drops++;
        m_ovf = 1;
      end else begin
        exp_q.push_back({last, ch, {{8{e[23]}}, e}});
      end
    end
    for (int j = 0; j < p; j++) begin
      if (j == abort_slot) begin
        sclk = 1'b0;
        cyc(2);
        chk("pre_reset_valid", tvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drops", drops, 0);
        exp_q.delete();
        fc = 0; synced = 0; m_lr_last = 0; m_drops = 0; m_ovf = 0; carry = 0;
        cyc(4);
        aresetn = 1'b1;
        cyc(4);
        return;
      end
      slot(ch, (j == 0) ? carry : ((j - 1 < 32) ? val[32 - j] : 1'b0), j == en_slot);
    end
    carry = (p <= 32) ? val[32 - p] : 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || tvalid) && t < 20000) begin cyc(1); t++; end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [33:0] prev_beat, cur, e;
    bit          prev_hold = 0;
    forever begin
      @(negedge clk);
      cur = {tlast, tuser, tdata};
      if (!aresetn) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) chk("hold_stable", {tvalid, cur}, {1'b1, prev_beat});
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got %h, expected no beat", cur);
          end else begin
            e = exp_q.pop_front();
            chk("beat", cur, e);
          end
          beat_log.push_back(cur);
        end
        prev_hold = tvalid && !tready;
        prev_beat = cur;
      end
    end
  end

  initial begin
    int mask;
    cyc(3);
    chk("reset_tvalid", tvalid, 0);
    chk("reset_tdata", tdata, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_drops", drops, 0);
    aresetn = 1'b1;
    cyc(4);

    set_en(1); cyc(2);
    beat_log.delete();
    word(1, 32'h55555555, 32, -1, -1);
    word(0, 32'h12345600, 32, -1, -1);
    word(1, 32'h89ABCD00, 32, -1, -1);
    drain();
    chk("nom_count", beat_log.size(), 2);
    if (beat_log.size() >= 2) begin
      chk("nom_left", beat_log[0], {1'b0, 1'b0, 32'h00123456});
      chk("nom_right", beat_log[1], {1'b0, 1'b1, 32'hFF89ABCD});
    end

    set_en(0); cyc(4); set_en(1); cyc(2);
    beat_log.delete();
    for (int i = 0; i < 16; i++) word(i[0], $urandom, 32, -1, -1);
    drain();
    chk("frame_count", beat_log.size(), 16);
    mask = 0;
    foreach (beat_log[i]) if (beat_log[i][33]) mask |= (1 << i);
    chk("frame_tlast_pos", mask, 32'h8080);

    stall = 1; cyc(2);
    for (int i = 0; i < 6; i++) word(i[0], 32'h11111100 * (i + 1), 32, -1, -1);
    cyc(20);
    chk("bp_model_held", exp_q.size(), 4);
    chk("bp_ovf", ovf, 1);
    chk("bp_drops", drops, 2);
    chk("bp_drops_model", drops, m_drops);
    chk("bp_tvalid", tvalid, 1);
    beat_log.delete();
    stall = 0;
    drain();
    chk("bp_out_count", beat_log.size(), 4);
    if (beat_log.size() >= 1) chk("bp_first", beat_log[0], {2'b00, 32'h00111111});
    i_clear_overflow = 1'b1; cyc(1); i_clear_overflow = 1'b0;
    m_drops = 0; m_ovf = 0;
    cyc(1);
    chk("clr_ovf", ovf, 0);
    chk("clr_drops", drops, 0);

    stall = 1; cyc(2);
    word(0, $urandom, 32, -1, -1);
    word(1, $urandom, 32, -1, -1);
    word(0, $urandom, 32, -1, 10);
    stall = 0;
    beat_log.delete();
    word(1, $urandom, 32, -1, -1);
    word(0, 32'h7FFFFF00, 32, -1, -1);
    word(1, $urandom, 32, -1, -1);
    word(0, $urandom, 32, -1, -1);
    drain();
    if (beat_log.size() >= 1) chk("post_reset_first", beat_log[0], {2'b00, 32'h007FFFFF});
    else chk("post_reset_count", beat_log.size(), 3);

    set_en(0); cyc(4);
    beat_log.delete();
    word(1, $urandom, 32, 8, -1);
    word(0, 32'h65432100, 32, -1, -1);
    word(1, $urandom, 32, -1, -1);
    drain();
    chk("midstream_count", beat_log.size(), 2);
    if (beat_log.size() >= 1) chk("midstream_first", beat_log[0], {2'b00, 32'h00654321});

    beat_log.delete();
    word(0, 32'hABCD0000, 16, -1, -1);
    word(1, $urandom, 32, -1, -1);
    drain();
    if (beat_log.size() >= 1) chk("short_word", beat_log[0], {2'b00, 32'hFFABCD00});
    else chk("short_count", beat_log.size(), 2);

    beat_log.delete();
    for (int i = 0; i < 30; i++) begin
      word(i[0], $urandom, (i == 29) ? 32 : int'($urandom_range(12, 34)), -1, -1);
    end
    drain();
    chk("rand_count", beat_log.size(), 30);
    chk("rand_drops", drops, m_drops);
    chk("rand_ovf", ovf, m_ovf);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/i2s_rx_axis.md
Name: i2s_rx_axis

Overview:
- Receives I2S serial audio (SCLK, LRCLK, SDATA) from an external codec.
- Deserialises each channel sample and emits it as an AXI4-Stream master feeding the I2S DMA S2MM write channel.
- Frames samples into packets: TLAST on the last right-channel sample of every FRAME_LEN stereo frames.
- Buffers samples in a small FIFO; drops and counts samples when the DMA back-pressures too long.

Parameters:
- SAMPLE_WIDTH, 24: captured bits per channel word, MSB first, range 8..32.
- FRAME_LEN, 256: stereo frames per packet, at least 2.
- FIFO_DEPTH, 4: output FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  system clock; must be at least 4x SCLK frequency.
- aresetn  in  1  asynchronous active-low reset.
- i_enable  in  1  capture enable.
- i_clear_overflow  in  1  single-cycle pulse; clears the overflow flag and drop counter.
- i2s_sclk  in  1  I2S bit clock, asynchronous to clk.
- i2s_lrclk  in  1  word select: 0 = left, 1 = right.
- i2s_sdata  in  1  serial data.
- m_axis_tdata  out  32  sample, sign-extended to 32 bits.
- m_axis_tuser  out  1  channel: 0 = left, 1 = right.
- m_axis_tlast  out  1  packet end.
- m_axis_tvalid  out  1  data valid.
- m_axis_tready  in  1  downstream ready.
- o_overflow  out  1  sticky flag: at least one sample dropped.
- o_drop_count  out  16  dropped samples, saturating at 0xFFFF.

Behaviour:
- Reset:
  - Every output is 0 and the FIFO is empty.
  - State is IDLE; bit counter and frame counter are 0.
  - Reset is asynchronous assert, synchronous release; mid-word reset discards the partial sample.
- Input sync: SCLK, LRCLK and SDATA each pass through a 2-FF synchroniser. A rising edge is "sync2=1 and prev=0". All capture logic acts only on edge cycles.
- FSM:
  - IDLE: entered when i_enable=0. Partial word discarded, frame counter cleared. FIFO keeps draining. i_enable=1 -> SYNC.
  - SYNC: wait for an edge where LRCLK goes 1->0 versus the previous edge. Set channel=0, cnt=0 -> SHIFT. This guarantees the first emitted sample is a left sample.
  - SHIFT: each edge shifts SDATA into the shift register MSB-first and increments cnt.
    - cnt reaches SAMPLE_WIDTH: push sample -> HOLD.
    - LRCLK transition first: shift in the bit, left-align (zero-pad the LSBs), push, load the new channel, cnt=0, stay in SHIFT.
  - HOLD: ignore SDATA until an LRCLK transition edge. Then channel=new LRCLK, cnt=0 -> SHIFT; the MSB is captured on the following edge (1-bit I2S delay).
  - i_enable=0 in any state -> IDLE next cycle.
- Push format:
  - tdata = sign-extend(sample).
  - tuser = channel.
  - tlast = 1 iff channel=1 and frame_cnt = FRAME_LEN-1.
  - frame_cnt increments on every right-channel push attempt, dropped or not, wrapping FRAME_LEN-1 -> 0.
- Latency: push is registered at the end of the edge cycle E. With the FIFO empty, tvalid=1 in cycle E+1.
- FIFO:
  - tvalid = not empty; tdata/tuser/tlast come from the head entry.
  - Pop on tvalid and tready.
  - Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Output beats hold stable while tvalid=1 and tready=0.
- Overflow:
  - Push with the FIFO full and no pop: sample discarded, o_overflow=1, o_drop_count+1 (saturating).
  - i_clear_overflow clears both. If a drop occurs in the same cycle, the drop wins: flag=1, count=1.
- Channel mismatch: none is possible. The FSM only restarts from SYNC, so left/right ordering holds except across drops.

Test Plan:
- Reset: aresetn=0 mid-word, with the FIFO holding 2 entries -> all outputs 0 immediately. After release, with i_enable=1, the first beat is a left sample.
- Nominal: 32 SCLK per channel, left=0x123456, right=0x89ABCD, tready=1 -> beats (0x00123456, tuser 0), then (0xFF89ABCD, tuser 1).
- Framing, FRAME_LEN=4: 8 stereo frames -> 16 beats; tlast=1 only on beats 8 and 16, both tuser=1.
- Backpressure, FIFO_DEPTH=4: tready=0 for 6 samples -> 4 held, o_overflow=1, o_drop_count=2. Then tready=1 -> first 4 samples out in order. i_clear_overflow -> flag 0, count 0.
- Mid-stream enable: i_enable rises during a right word -> no output until the next LRCLK 1->0; the first beat has tuser=0 with the correct value.
- Short word: LRCLK toggles after 16 data bits of 0xABCD (SAMPLE_WIDTH=24) -> tdata 0xFFABCD00.
